// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared fixed-latency ALU.
// Latches one operation per grant, waits ALU_LAT cycles, then holds the result until the consumer takes it.
module alu_arbiter_ctrl #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req1_valid,
    output logic       req0_ready,
    output logic       req1_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [3:0] req0_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [3:0] req1_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_opcode,
    input  logic [3:0] alu_out,
    input  logic       alu_z,
    input  logic       alu_c,
    input  logic       alu_v,
    input  logic       alu_p,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_out,
    output logic [3:0] rsp_flags,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] lat_cnt;
    logic       last_id;   // requester that completed most recently; resets to 1 so requester 0 wins the first tie
    logic       grant;
    logic       grant_id;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                // Reset gates the grant so a request seen during reset is never acknowledged.
                if (!rst && (req0_valid || req1_valid)) begin
                    grant      = 1'b1;
                    grant_id   = (req0_valid && req1_valid) ? ~last_id : req1_valid;
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values and updates together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            alu_opcode <= 4'd0;
            rsp_id     <= 1'b0;
            rsp_out    <= 4'd0;
            rsp_flags  <= 4'd0;
            lat_cnt    <= 4'd0;
            last_id    <= 1'b1;
        end else begin
            if (grant) begin
                alu_a      <= grant_id ? req1_a  : req0_a;
                alu_b      <= grant_id ? req1_b  : req0_b;
                alu_opcode <= grant_id ? req1_op : req0_op;
                rsp_id     <= grant_id;
                lat_cnt    <= 4'(ALU_LAT);
            end
            if (state == EXEC) begin
                lat_cnt <= lat_cnt - 4'd1;
                // The count reads 1 exactly ALU_LAT cycles after the grant edge.
                if (lat_cnt == 4'd1) begin
                    rsp_out   <= alu_out;
                    rsp_flags <= {alu_z, alu_c, alu_v, alu_p};
                end
            end
            if (rsp_valid && rsp_ready) begin
                last_id <= rsp_id;
            end
        end
    end

endmodule
